// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. One trial subtraction per clock
//   produces one quotient bit, MSB first, so a division takes WIDTH cycles
//   in CALC. Operands are loaded with a start/done handshake. Divide by zero
//   skips CALC and reports an all-ones quotient with remainder = dividend.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      load operands and begin (ignored while busy)
//   dividend   in   WIDTH  unsigned dividend, sampled on accepted start
//   divisor    in   WIDTH  unsigned divisor, sampled on accepted start
//   busy       out  1      high while the divider is iterating
//   done       out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  quotient, held until the next result
//   remainder  out  WIDTH  remainder, held until the next result
//   div_zero   out  1      last accepted operation had divisor == 0
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit
   logic [WIDTH-1:0] wq_q, wq_d;         // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH:0]   step_rem_s;
   logic [WIDTH-1:0] step_q_s;

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   always_comb begin
      shifted_s = {rem_q[WIDTH-1:0], wq_q[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, dvs_q};
      if (diff_s[WIDTH] == 1'b0) begin
         step_rem_s = diff_s;
         step_q_s   = {wq_q[WIDTH-2:0], 1'b1};
      end else begin
         step_rem_s = shifted_s;
         step_q_s   = {wq_q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state logic for control, working registers and result registers.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      wq_d        = wq_q;
      dvs_d       = dvs_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         S_CALC: begin
            rem_d   = step_rem_s;
            wq_d    = step_q_s;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d     = S_DONE;
               quotient_d  = step_q_s;
               remainder_d = step_rem_s[WIDTH-1:0];
            end else begin
               state_d = S_CALC;
            end
         end
         S_IDLE, S_DONE: begin
            if (start) begin
               rem_d   = {(WIDTH+1){1'b0}};
               wq_d    = dividend;
               dvs_d   = divisor;
               count_d = {CW{1'b0}};
               if (divisor == {WIDTH{1'b0}}) begin
                  // No iterations: result is fixed, publish it immediately.
                  state_d     = S_DONE;
                  quotient_d  = {WIDTH{1'b1}};
                  remainder_d = dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d    = S_CALC;
                  div_zero_d = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Status outputs are registered copies of the state being entered.
      busy_d = (state_d == S_CALC);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rem_q       <= {(WIDTH+1){1'b0}};
         wq_q        <= {WIDTH{1'b0}};
         dvs_q       <= {WIDTH{1'b0}};
         count_q     <= {CW{1'b0}};
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         div_zero_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         wq_q        <= wq_d;
         dvs_q       <= dvs_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Directed vectors with hand-computed results, multi-cycle corner cases
//   (start while busy, reset mid-operation) and an exhaustive sweep run with
//   back-to-back starts issued in the done cycle.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   // 10 time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
      int           busy_cycles;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Drive start for exactly one rising edge; returns #1 after that edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen (bounded), and busy cycles meanwhile.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cycles++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bc;
      int done_seen;
      int a;
      int b;

      //            a      b      q      r     dz  lat busy
      vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4, 4};
      vecs[1] = '{4'd5,  4'd0,  4'hF,  4'd5, 1'b1, 0, 0};
      vecs[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4, 4};
      vecs[3] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 4, 4};
      vecs[4] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 0, 0};
      vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4, 4};
      vecs[6] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0, 4, 4};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      #12;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_q", int'(quotient), 0);
      check("reset_r", int'(remainder), 0);
      check("reset_dz", int'(div_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_no_done", int'(done), 0);

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_busy", i), bc, vecs[i].busy_cycles);
         check($sformatf("v%0d_q", i), int'(quotient), int'(vecs[i].q));
         check($sformatf("v%0d_r", i), int'(remainder), int'(vecs[i].r));
         check($sformatf("v%0d_dz", i), int'(div_zero), int'(vecs[i].dz));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_drop", i), int'(done), 0);
         check($sformatf("v%0d_q_held", i), int'(quotient), int'(vecs[i].q));
      end

      // Start while busy is ignored; outputs hold the previous result in CALC.
      start_op(4'd9, 4'd2);
      check("calc_q_held", int'(quotient), 2);
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      wait_done(lat, bc);
      check("ign_lat", lat, 2);
      check("ign_q", int'(quotient), 4);
      check("ign_r", int'(remainder), 1);
      start_op(4'd14, 4'd3);
      check("hold_q_in_calc", int'(quotient), 4);
      check("hold_r_in_calc", int'(remainder), 1);
      wait_done(lat, bc);
      check("b14_3_lat", lat, 4);
      check("b14_3_q", int'(quotient), 4);
      check("b14_3_r", int'(remainder), 2);

      // Reset in the second CALC cycle.
      start_op(4'd12, 4'd5);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_q", int'(quotient), 0);
      check("mid_rst_r", int'(remainder), 0);
      check("mid_rst_dz", int'(div_zero), 0);
      check("mid_rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_seen++;
      end
      check("no_done_after_rst", done_seen, 0);
      start_op(4'd12, 4'd5);
      wait_done(lat, bc);
      check("post_rst_lat", lat, 4);
      check("post_rst_q", int'(quotient), 2);
      check("post_rst_r", int'(remainder), 2);

      // Exhaustive sweep, each start issued in the previous done cycle.
      for (a = 0; a < 16; a++) begin
         for (b = 1; b < 16; b++) begin
            start_op(W'(a), W'(b));
            wait_done(lat, bc);
            check($sformatf("ex_%0d_%0d_lat", a, b), lat, 4);
            check($sformatf("ex_%0d_%0d_q", a, b), int'(quotient), a / b);
            check($sformatf("ex_%0d_%0d_r", a, b), int'(remainder), a % b);
            check($sformatf("ex_%0d_%0d_inv", a, b),
                  int'((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)), 1);
         end
      end
      @(posedge clk);
      #1;
      check("final_done_drop", int'(done), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
